// File: rtl/timer_dev.sv
// timer_dev: bus-mapped countdown timer (CTRL/PRESET/COUNT) with one-shot or
// auto-reload operation and an interrupt request gated by CTRL.IM.
module timer_dev #(
   parameter logic [31:0] BASE = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  byteen,
   output logic [31:0] rdata,
   output logic        hit,
   output logic        irq
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   localparam logic [1:0] SEL_CTRL   = 2'd0;
   localparam logic [1:0] SEL_PRESET = 2'd1;
   localparam logic [1:0] MODE_AUTO  = 2'd1;

   state_t      r_state;
   logic [3:0]  r_ctrl;     // {IM, MODE[1:0], EN}
   logic [31:0] r_preset;
   logic [31:0] r_count;
   logic        r_pending;

   logic [31:0] w_off;
   logic [1:0]  w_sel;
   logic        w_wr;
   logic [31:0] w_preset_merged;

   // Addresses below BASE wrap to huge offsets, so one compare bounds both ends.
   assign w_off = addr - BASE;
   assign hit   = (w_off < 32'd12);
   assign w_sel = w_off[3:2];
   assign w_wr  = hit & (byteen != 4'b0000);

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_preset_merged[8*i +: 8] = byteen[i] ? wdata[8*i +: 8] : r_preset[8*i +: 8];
      end
   end

   always_comb begin
      // NOTE: default first so every path assigns rdata and no latch is inferred.
      rdata = 32'h0000_0000;
      if (hit) begin
         case (w_sel)
            SEL_CTRL:   rdata = {28'h000_0000, r_ctrl};
            SEL_PRESET: rdata = r_preset;
            default:    rdata = r_count;
         endcase
      end
   end

   assign irq = r_ctrl[3] & ((r_state == INT) | r_pending);

   // NOTE: non-blocking assignments throughout; the bus write comes last in the
   // block so a CPU update to CTRL wins over the FSM's EN clear on the same edge.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous and tested first, so it also beats a bus write.
      if (!reset) begin
         r_state   <= IDLE;
         r_ctrl    <= 4'h0;
         r_preset  <= 32'h0000_0000;
         r_count   <= 32'h0000_0000;
         r_pending <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_ctrl[0]) r_state <= LOAD;
            end
            LOAD: begin
               r_count <= r_preset;
               r_state <= CNT;
            end
            CNT: begin
               if (!r_ctrl[0])               r_state <= IDLE;
               else if (r_count == 32'd0)    r_state <= INT;
               else                          r_count <= r_count - 32'd1;
            end
            INT: begin
               if (r_ctrl[2:1] == MODE_AUTO) begin
                  r_state <= LOAD;
               end else begin
                  r_pending <= 1'b1;
                  r_ctrl[0] <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase

         if (w_wr) begin
            case (w_sel)
               SEL_CTRL: begin
                  if (byteen[0]) begin
                     r_ctrl <= wdata[3:0];
                     if (wdata[0]) r_pending <= 1'b0;
                  end
               end
               SEL_PRESET: r_preset <= w_preset_merged;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed scenarios against spec-derived
// constants, plus a randomized run against a cycle-offset reference model.
module tb_timer_dev;

   localparam logic [31:0] BASE = 32'h0000_7F00;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  byteen;
   logic [31:0] rdata;
   logic        hit;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   timer_dev #(.BASE(BASE)) dut (
      .clk    (clk),
      .reset  (reset),
      .addr   (addr),
      .wdata  (wdata),
      .byteen (byteen),
      .rdata  (rdata),
      .hit    (hit),
      .irq    (irq)
   );

   // Reference model: a run is tracked by the number of cycles since LOAD was
   // entered (m_t). COUNT and INT are derived arithmetically from m_t and the
   // PRESET value captured at LOAD.
   logic [3:0]  m_ctrl;
   logic [31:0] m_preset;
   logic [31:0] m_lat;
   logic [31:0] m_held;
   logic        m_pending;
   logic        m_run;
   longint      m_t;

   function automatic logic m_in_int();
      return m_run && (m_t == longint'(m_lat) + 2);
   endfunction

   function automatic logic [31:0] m_count();
      if (m_run && m_t >= 1 && m_t <= longint'(m_lat) + 1) return m_lat - 32'(m_t - 1);
      if (m_in_int()) return 32'd0;
      return m_held;
   endfunction

   function automatic logic m_hit(input logic [31:0] a);
      return (longint'(a) >= longint'(BASE)) && (longint'(a) <= longint'(BASE) + 11);
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      longint off;
      off = longint'(a) - longint'(BASE);
      if (!m_hit(a)) return 32'd0;
      case (off / 4)
         0:       return {28'd0, m_ctrl};
         1:       return m_preset;
         default: return m_count();
      endcase
   endfunction

   function automatic logic m_irq();
      return m_ctrl[3] & (m_in_int() | m_pending);
   endfunction

   task automatic m_edge(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be);
      logic [3:0]  n_ctrl;
      logic [31:0] n_preset, n_lat, n_held, cur;
      logic        n_pending, n_run;
      longint      n_t;
      if (!rst) begin
         m_ctrl = 4'h0; m_preset = 32'd0; m_lat = 32'd0; m_held = 32'd0;
         m_pending = 1'b0; m_run = 1'b0; m_t = 0;
         return;
      end
      cur = m_count();
      n_ctrl = m_ctrl; n_preset = m_preset; n_lat = m_lat; n_held = m_held;
      n_pending = m_pending; n_run = m_run; n_t = m_t;
      if (!m_run) begin
         if (m_ctrl[0]) begin n_run = 1'b1; n_t = 0; end
      end else if (m_t == 0) begin
         n_lat = m_preset; n_t = 1;
      end else if (m_in_int()) begin
         n_held = 32'd0;
         if (m_ctrl[2:1] == 2'd1) n_t = 0;
         else begin n_run = 1'b0; n_pending = 1'b1; n_ctrl[0] = 1'b0; end
      end else if (!m_ctrl[0]) begin
         n_run = 1'b0; n_held = cur;
      end else begin
         n_t = m_t + 1;
      end
      if (m_hit(a) && be != 4'b0000) begin
         case ((longint'(a) - longint'(BASE)) / 4)
            0: if (be[0]) begin
                  n_ctrl = wd[3:0];
                  if (wd[0]) n_pending = 1'b0;
               end
            1: for (int i = 0; i < 4; i++) if (be[i]) n_preset[8*i +: 8] = wd[8*i +: 8];
            default: ;
         endcase
      end
      m_ctrl = n_ctrl; m_preset = n_preset; m_lat = n_lat; m_held = n_held;
      m_pending = n_pending; m_run = n_run; m_t = n_t;
   endtask

   // One clock edge; the model sees the same inputs the DUT sampled.
   task automatic tick();
      logic        s_rst;
      logic [31:0] s_a, s_d;
      logic [3:0]  s_be;
      s_rst = reset; s_a = addr; s_d = wdata; s_be = byteen;
      @(posedge clk);
      m_edge(s_rst, s_a, s_d, s_be);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      addr = a; wdata = d; byteen = be;
      tick();
      byteen = 4'b0000;
   endtask

   task automatic rd(input logic [31:0] a);
      addr = a;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; byteen = 4'b0000;
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; addr = BASE; wdata = 32'd0; byteen = 4'b0000;
      tick(); tick();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rd(BASE + 32'(4 * i));
         n_checks++;
         if (rdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_reg%0d got=%h exp=%h", i, rdata, 32'd0);
         end
         n_checks++;
         if (hit !== 1'b1) begin
            n_fail++; $display("FAIL reset_hit%0d got=%b exp=1", i, hit);
         end
      end
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
   endtask

   task automatic test_oneshot();
      logic [31:0] exp_cnt;
      do_reset();
      wr(BASE + 4, 32'd3, 4'hF);
      wr(BASE, 32'h9, 4'h1);            // edge 0
      addr = BASE + 8;
      for (int e = 1; e <= 10; e++) begin
         tick();
         exp_cnt = (e < 2) ? 32'd0 : (e <= 5) ? 32'(5 - e) : 32'd0;
         n_checks++;
         if (rdata !== exp_cnt) begin
            n_fail++; $display("FAIL oneshot_count_e%0d got=%0d exp=%0d", e, rdata, exp_cnt);
         end
         n_checks++;
         if (irq !== (e >= 6)) begin
            n_fail++; $display("FAIL oneshot_irq_e%0d got=%b exp=%b", e, irq, (e >= 6));
         end
      end
      rd(BASE);
      n_checks++;
      if (rdata !== 32'h8) begin n_fail++; $display("FAIL oneshot_ctrl got=%h exp=%h", rdata, 32'h8); end
      wr(BASE, 32'h9, 4'h1);            // clears pending, restarts
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL pending_clear_irq got=%b exp=0", irq); end
   endtask

   task automatic test_autoreload();
      logic exp_irq;
      do_reset();
      wr(BASE + 4, 32'd3, 4'hF);
      wr(BASE, 32'hB, 4'h1);            // edge 0
      addr = BASE + 8;
      for (int e = 1; e <= 25; e++) begin
         tick();
         exp_irq = (e >= 6) && (e % 6 == 0);
         n_checks++;
         if (irq !== exp_irq) begin
            n_fail++; $display("FAIL autoreload_irq_e%0d got=%b exp=%b", e, irq, exp_irq);
         end
      end
      rd(BASE);
      n_checks++;
      if (rdata !== 32'hB) begin n_fail++; $display("FAIL autoreload_ctrl got=%h exp=%h", rdata, 32'hB); end
   endtask

   task automatic test_stop();
      do_reset();
      wr(BASE + 4, 32'd10, 4'hF);
      wr(BASE, 32'h9, 4'h1);            // edge 0; COUNT after edge e is 12-e
      byteen = 4'b0000;
      for (int e = 1; e <= 4; e++) tick();
      wr(BASE, 32'h8, 4'h1);            // edge 5: COUNT becomes 7, EN cleared
      addr = BASE + 8;
      for (int e = 6; e <= 11; e++) begin
         tick();
         n_checks++;
         if (rdata !== 32'd7) begin
            n_fail++; $display("FAIL stop_count_e%0d got=%0d exp=7", e, rdata);
         end
         n_checks++;
         if (irq !== 1'b0) begin n_fail++; $display("FAIL stop_irq_e%0d got=%b exp=0", e, irq); end
      end
   endtask

   task automatic test_bytelane();
      do_reset();
      wr(BASE + 4, 32'h1122_3344, 4'hF);
      wr(BASE + 4, 32'h0000_AB00, 4'b0010);
      rd(BASE + 4);
      n_checks++;
      if (rdata !== 32'h1122_AB44) begin
         n_fail++; $display("FAIL bytelane_preset got=%h exp=%h", rdata, 32'h1122_AB44);
      end
      wr(BASE + 8, 32'hFFFF_FFFF, 4'hF);
      rd(BASE + 8);
      n_checks++;
      if (rdata !== 32'd0) begin n_fail++; $display("FAIL count_readonly got=%h exp=%h", rdata, 32'd0); end
      wr(BASE, 32'hFFFF_FFF8, 4'hF);
      rd(BASE);
      n_checks++;
      if (rdata !== 32'h8) begin n_fail++; $display("FAIL ctrl_unused_bits got=%h exp=%h", rdata, 32'h8); end
   endtask

   task automatic test_decode();
      rd(BASE + 12);
      n_checks++;
      if (hit !== 1'b0) begin n_fail++; $display("FAIL decode_hit_b12 got=%b exp=0", hit); end
      n_checks++;
      if (rdata !== 32'd0) begin n_fail++; $display("FAIL decode_rdata_b12 got=%h exp=0", rdata); end
      rd(BASE + 5);
      n_checks++;
      if (rdata !== 32'h1122_AB44) begin
         n_fail++; $display("FAIL decode_b5 got=%h exp=%h", rdata, 32'h1122_AB44);
      end
      rd(BASE - 1);
      n_checks++;
      if (hit !== 1'b0) begin n_fail++; $display("FAIL decode_hit_below got=%b exp=0", hit); end
      rd(BASE + 11);
      n_checks++;
      if (hit !== 1'b1) begin n_fail++; $display("FAIL decode_hit_b11 got=%b exp=1", hit); end
      wr(BASE + 16, 32'h5, 4'hF);
      wr(BASE + 20, 32'h0, 4'hF);
      rd(BASE);
      n_checks++;
      if (rdata !== 32'h8) begin n_fail++; $display("FAIL miss_write_ctrl got=%h exp=%h", rdata, 32'h8); end
      rd(BASE + 4);
      n_checks++;
      if (rdata !== 32'h1122_AB44) begin
         n_fail++; $display("FAIL miss_write_preset got=%h exp=%h", rdata, 32'h1122_AB44);
      end
   endtask

   task automatic test_preset0();
      do_reset();
      wr(BASE, 32'h9, 4'h1);            // edge 0, LOAD at 1, INT at 3
      addr = BASE + 8;
      for (int e = 1; e <= 6; e++) begin
         tick();
         n_checks++;
         if (irq !== (e >= 3)) begin
            n_fail++; $display("FAIL preset0_irq_e%0d got=%b exp=%b", e, irq, (e >= 3));
         end
         n_checks++;
         if (rdata !== 32'd0) begin
            n_fail++; $display("FAIL preset0_count_e%0d got=%h exp=0", e, rdata);
         end
      end
   endtask

   task automatic test_preset_in_cnt();
      logic exp_irq;
      do_reset();
      wr(BASE + 4, 32'd5, 4'hF);
      wr(BASE, 32'hB, 4'h1);            // edge 0, INT at 8, then period 5 with PRESET=2
      for (int e = 1; e <= 30; e++) begin
         if (e == 4) wr(BASE + 4, 32'd2, 4'hF);
         else begin addr = BASE + 8; tick(); end
         addr = BASE + 8; #1;
         if (e >= 2 && e <= 7) begin
            n_checks++;
            if (rdata !== 32'(7 - e)) begin
               n_fail++; $display("FAIL presetcnt_count_e%0d got=%0d exp=%0d", e, rdata, 7 - e);
            end
         end
         exp_irq = (e == 8) || (e >= 13 && (e - 13) % 5 == 0);
         n_checks++;
         if (irq !== exp_irq) begin
            n_fail++; $display("FAIL presetcnt_irq_e%0d got=%b exp=%b", e, irq, exp_irq);
         end
      end
   endtask

   task automatic test_reset_mid();
      int guard;
      do_reset();
      wr(BASE + 4, 32'd3, 4'hF);
      wr(BASE, 32'h9, 4'h1);
      guard = 0;
      while (irq !== 1'b1 && guard < 20) begin tick(); guard++; end
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL resetmid_wait_irq got=%b exp=1", irq); end
      reset = 1'b0;                     // reset with a colliding PRESET write
      wr(BASE + 4, 32'h77, 4'hF);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rd(BASE + 32'(4 * i));
         n_checks++;
         if (rdata !== 32'd0) begin
            n_fail++; $display("FAIL resetmid_reg%0d got=%h exp=0", i, rdata);
         end
      end
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL resetmid_irq got=%b exp=0", irq); end
      wr(BASE + 4, 32'd4, 4'hF);
      wr(BASE, 32'h9, 4'h1);            // edge 0
      addr = BASE + 8;
      tick(); tick(); tick();           // COUNT after edge 3 is 3
      n_checks++;
      if (rdata !== 32'd3) begin n_fail++; $display("FAIL restart_count got=%0d exp=3", rdata); end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         n_checks++;
         if (irq !== 1'b0 || rdata !== 32'd0) begin
            n_fail++; $display("FAIL abort_e%0d irq=%b count=%0d exp irq=0 count=0", e, irq, rdata);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 63) != 0);
         a = ($urandom_range(0, 7) == 0) ? $urandom : BASE + 32'($urandom_range(0, 15));
         addr = a;
         wdata = $urandom;
         if (m_hit(a) && (a - BASE) / 4 == 1 && $urandom_range(0, 3) != 0)
            wdata = 32'($urandom_range(0, 12));
         byteen = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
         tick();
         byteen = 4'b0000;
         n_checks++;
         if (hit !== m_hit(a) || rdata !== m_read(a)) begin
            n_fail++;
            $display("FAIL rand_c%0d addr=%h hit=%b rdata=%h exp hit=%b rdata=%h",
                     c, a, hit, rdata, m_hit(a), m_read(a));
         end
         n_checks++;
         if (irq !== m_irq()) begin
            n_fail++; $display("FAIL rand_irq_c%0d got=%b exp=%b", c, irq, m_irq());
         end
         a = BASE + 32'(4 * $urandom_range(0, 2) + $urandom_range(0, 3));
         rd(a);
         n_checks++;
         if (rdata !== m_read(a)) begin
            n_fail++; $display("FAIL rand_rd_c%0d addr=%h got=%h exp=%h", c, a, rdata, m_read(a));
         end
      end
      reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_autoreload();
      test_stop();
      test_bytelane();
      test_decode();
      test_preset0();
      test_preset_in_cnt();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 The block SHALL have parameter BASE, default 32'h0000_7F00, meaning the word-aligned base address of its 3-word register window.
REQ-002 The block SHALL have port clk, input, 1, meaning the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, meaning a synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
REQ-004 The block SHALL have port addr, input, 32, meaning the CPU data-bus byte address (m_data_addr).
REQ-005 The block SHALL have port wdata, input, 32, meaning the CPU store data, already lane-aligned (m_data_wdata).
REQ-006 The block SHALL have port byteen, input, 4, meaning the per-byte write enables (m_data_byteen); 4'b0000 means no write.
REQ-007 The block SHALL have port rdata, output, 32, meaning the combinational read data for addr.
REQ-008 The block SHALL have port hit, output, 1, meaning addr lies within [BASE, BASE+11].
REQ-009 The block SHALL have port irq, output, 1, meaning the interrupt request, wired to one HWInt bit.

Function
REQ-010 The block SHALL provide register CTRL at BASE+0 (bit0 EN, bits2:1 MODE, bit3 IM; other bits read 0), PRESET at BASE+4 (R/W) and COUNT at BASE+8 (read-only).
REQ-011 The block SHALL select the register by addr[3:2] and SHALL ignore addr[1:0].
REQ-012 A write SHALL occur on a clk edge when hit=1 and byteen!=0, merging only the enabled byte lanes into the target register.
REQ-013 Writes to COUNT and to unused CTRL bits SHALL be ignored; writes with hit=0 SHALL change no state.
REQ-014 When hit=1, rdata SHALL return the addressed register; when hit=0, rdata SHALL be 0; there SHALL be zero read latency.
REQ-015 The block SHALL implement the FSM states IDLE, LOAD, CNT and INT.
REQ-016 In IDLE, if EN=1 the FSM SHALL go to LOAD; otherwise it SHALL stay in IDLE with COUNT held.
REQ-017 In LOAD, the block SHALL set COUNT<=PRESET and go to CNT.
REQ-018 In CNT with EN=0, the FSM SHALL go to IDLE with COUNT held; with COUNT==0, it SHALL go to INT; otherwise COUNT<=COUNT-1.
REQ-019 In INT with MODE==1 (auto-reload), the FSM SHALL go to LOAD.
REQ-020 In INT with any other MODE (0, 2 or 3 one-shot), the block SHALL set pending<=1, clear EN, and go to IDLE.
REQ-021 The block SHALL drive irq = IM & (state==INT | pending), combinationally from registers.
REQ-022 Latency: with the EN=1 write on edge N and PRESET=P, LOAD SHALL be entered at N+1, COUNT=P at N+2, INT at N+3+P; the auto-reload period SHALL be P+3 cycles.
REQ-023 A CPU write to CTRL SHALL override the FSM's EN clear on the same edge.
REQ-024 Any CTRL write with wdata bit0=1 and byteen[0]=1 SHALL clear pending.
REQ-025 A PRESET write while in CNT SHALL take effect only at the next LOAD.
REQ-026 PRESET=0 SHALL give INT two cycles after LOAD (no underflow); COUNT SHALL never wrap below 0.

Reset
REQ-027 On reset=0 at an edge, the block SHALL set CTRL=0, PRESET=0, COUNT=0, pending=0 and state=IDLE, so irq=0; rdata and hit SHALL remain combinational from addr.
REQ-028 Reset asserted mid-count SHALL abort counting with no irq, and reset SHALL take priority over a simultaneous bus write.

Verification
REQ-029 Write PRESET=3, then CTRL=0x9 (EN, mode 0, IM) at edge 0 -> COUNT reads 3,2,1,0 after edges 2-5, irq=1 from edge 6 onward, CTRL reads 0x8.
REQ-030 Same as REQ-029 with CTRL=0xB (mode 1) -> irq is a one-cycle pulse after edges 6, 12, 18 and so on.
REQ-031 Counting with PRESET=10, then write CTRL=0x8 when COUNT=7 -> next edge IDLE, COUNT holds 7, irq stays 0.
REQ-032 Write byteen=4'b0010, wdata=0x0000_AB00 to PRESET=0x11223344 -> PRESET reads 0x1122AB44; write to BASE+8 -> COUNT unchanged.
REQ-033 Read addr=BASE+12 -> hit=0, rdata=0; read BASE+5 -> returns PRESET.
REQ-034 With irq high (mode 0), pulse reset=0 for one edge -> all registers 0, irq=0; a subsequent EN=1 write restarts at LOAD.
